f_bpu: RTL and testbench

Fetch-stage branch predictor, the counterpart to the decode-stage branch comparator. In F it predicts each conditional branch (`beq`/`bne`) with a table of 2-bit saturating counters and supplies a speculative next PC. The core has no delay slot: the instruction fetched after a branch is speculative. When the branch reaches D, the comparator's decision retires the prediction, trains the table and, on mismatch, raises a redirect.

---
 rtl/bpu_pkg.sv | 39 +++
 rtl/bpu_pht.sv | 33 +++
 rtl/f_bpu.sv | 114 +++++++++++
 tb/tb_f_bpu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
package bpu_pkg;

    localparam int unsigned BPU_IDX_W = 6;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = WNT;

    // Direction-independent payload carried from F into D with the branch.
    typedef struct packed {
        logic        pred;
        logic [31:0] target;
        logic [31:0] fall;
    } pend_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        unique case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: 2-bit counters, async read, sync saturating update.
module bpu_pht
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W = BPU_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output ctr_e             rd_ctr_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             taken_i
);

    localparam int unsigned N = 1 << IDX_W;

    ctr_e ctr_q [N];

    assign rd_ctr_o = ctr_q[rd_idx_i];

    // Clear to weak-not-taken on reset, otherwise train the written entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else if (we_i) begin
            ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], taken_i);
        end
    end

endmodule

// File: rtl/f_bpu.sv
// Fetch-stage beq/bne predictor with D-stage resolve, training and perf counters.
module f_bpu
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W = BPU_IDX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    input  logic        stall,
    input  logic        D_taken,
    output logic        F_pred_taken,
    output logic [31:0] F_pred_pc,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_cnt,
    output logic [15:0] miss_cnt
);

    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    pend_t            pend_q, pend_d;
    logic [15:0]      br_cnt_q, br_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;

    logic             f_is_br;
    logic [31:0]      f_target;
    logic [31:0]      f_fall;
    logic [IDX_W-1:0] f_idx;
    ctr_e             f_ctr;
    logic             resolve;
    logic             unused_instr;

    assign f_idx        = F_pc[IDX_W+1:2];
    assign unused_instr = ^F_instr[25:16];

    bpu_pht #(
        .IDX_W (IDX_W)
    ) u_pht (
        .clk      (clk),
        .rst_n    (reset),
        .rd_idx_i (f_idx),
        .rd_ctr_o (f_ctr),
        .we_i     (resolve),
        .wr_idx_i (idx_q),
        .taken_i  (D_taken)
    );

    // F prediction, D resolve and next-state for the pending register and counters.
    always_comb begin
        f_is_br      = 1'b0;
        f_target     = '0;
        f_fall       = '0;
        resolve      = 1'b0;
        F_pred_taken = 1'b0;
        F_pred_pc    = '0;
        mispredict   = 1'b0;
        redirect_pc  = '0;
        valid_d      = valid_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        br_cnt_d     = br_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        f_is_br  = (F_instr[31:26] == OP_BEQ) || (F_instr[31:26] == OP_BNE);
        f_fall   = F_pc + 32'd4;
        f_target = f_fall + {{14{F_instr[15]}}, F_instr[15:0], 2'b00};

        F_pred_taken = f_is_br & f_ctr[1];
        F_pred_pc    = F_pred_taken ? f_target : f_fall;

        resolve     = valid_q & ~stall;
        mispredict  = resolve & (D_taken != pend_q.pred);
        redirect_pc = D_taken ? pend_q.target : pend_q.fall;

        if (!stall) begin
            // A mispredict squashes the wrong-path instruction now in F.
            valid_d     = f_is_br & ~mispredict;
            idx_d       = f_idx;
            pend_d.pred   = F_pred_taken;
            pend_d.target = f_target;
            pend_d.fall   = f_fall;
        end

        if (resolve) begin
            br_cnt_d = br_cnt_q + 16'd1;
            if (mispredict) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    // Pending F/D shadow and perf counter state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            idx_q      <= '0;
            pend_q     <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_f_bpu.sv
// Directed vector table plus randomized run against a behavioural predictor model.
module tb_f_bpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        stall;
    logic        D_taken;
    logic        F_pred_taken;
    logic [31:0] F_pred_pc;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt;
    logic [15:0] miss_cnt;

    f_bpu #(.IDX_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .F_pc         (F_pc),
        .F_instr      (F_instr),
        .stall        (stall),
        .D_taken      (D_taken),
        .F_pred_taken (F_pred_taken),
        .F_pred_pc    (F_pred_pc),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .br_cnt       (br_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Behavioural model: table of counters 0..3, one in-flight branch, two counts.
    int          m_ctr [64];
    bit          m_valid;
    int          m_idx;
    bit          m_pred;
    logic [31:0] m_tgt, m_fall;
    int          m_br, m_miss;
    bit          m_init = 0;

    bit          c_rst, c_stall, c_dt, c_isbr, c_pt, c_mis;
    int          c_idx;
    logic [31:0] c_tgt, c_fall;

    // Drive one cycle of inputs, then compare DUT outputs against the model.
    task automatic drive_and_check(input logic rst, input logic [31:0] pc,
                                   input logic [31:0] instr, input logic st, input logic dt);
        int simm;
        @(negedge clk);
        reset = rst; F_pc = pc; F_instr = instr; stall = st; D_taken = dt;
        #1;
        simm    = int'($signed(instr[15:0]));
        c_rst   = !rst;
        c_stall = st;
        c_dt    = dt;
        c_isbr  = (instr[31:26] == 6'd4) || (instr[31:26] == 6'd5);
        c_idx   = int'((pc / 4) % 64);
        c_fall  = pc + 32'd4;
        c_tgt   = pc + 32'd4 + 32'(simm * 4);
        c_pt    = c_isbr && (m_ctr[c_idx] >= 2);
        c_mis   = m_valid && !st && (dt != m_pred);
        if (m_init && rst) begin
            chk("model_pred_taken", 32'(F_pred_taken), 32'(c_pt));
            chk("model_pred_pc", F_pred_pc, c_pt ? c_tgt : c_fall);
            chk("model_mispredict", 32'(mispredict), 32'(c_mis));
            if (c_mis) chk("model_redirect_pc", redirect_pc, dt ? m_tgt : m_fall);
            chk("model_br_cnt", 32'(br_cnt), 32'(m_br));
            chk("model_miss_cnt", 32'(miss_cnt), 32'(m_miss));
        end
    endtask

    // Advance through the rising edge and apply the same edge to the model.
    task automatic clock_edge();
        @(posedge clk);
        if (c_rst) begin
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            m_valid = 0; m_br = 0; m_miss = 0; m_init = 1;
        end else if (!c_stall) begin
            if (m_valid) begin
                m_ctr[m_idx] = c_dt ? ((m_ctr[m_idx] < 3) ? m_ctr[m_idx] + 1 : 3)
                                    : ((m_ctr[m_idx] > 0) ? m_ctr[m_idx] - 1 : 0);
                m_br = (m_br + 1) % 65536;
                if (c_mis) m_miss = (m_miss + 1) % 65536;
            end
            m_valid = c_isbr && !c_mis;
            m_idx   = c_idx;
            m_pred  = c_pt;
            m_tgt   = c_tgt;
            m_fall  = c_fall;
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        st;
        logic        dt;
        logic        chk_en;
        logic        ept;
        logic [31:0] eppc;
        logic        emis;
        logic [31:0] erpc;
        logic [15:0] ebr;
        logic [15:0] emiss;
    } vec_t;

    localparam logic [31:0] BEQ4  = 32'h1000_0004;
    localparam logic [31:0] BNEM1 = 32'h1400_FFFF;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    vec_t tv [20];

    initial begin
        logic [31:0] r, pc, instr;
        logic [5:0]  op;

        reset = 1'b0; F_pc = '0; F_instr = '0; stall = 1'b0; D_taken = 1'b0;

        //        rst  pc           instr  st dt  chk pt  ppc          mis rpc          br     miss
        tv[0]  = '{0, 32'h0,    NOP,   0, 0,  0, 0, 32'h0,    0, 32'h0,    16'd0, 16'd0};
        tv[1]  = '{1, 32'h3000, BEQ4,  0, 0,  1, 0, 32'h3004, 0, 32'h0,    16'd0, 16'd0};
        tv[2]  = '{1, 32'h3000, BEQ4,  0, 1,  1, 0, 32'h3004, 1, 32'h3014, 16'd0, 16'd0};
        tv[3]  = '{1, 32'h3000, BEQ4,  0, 0,  1, 1, 32'h3014, 0, 32'h0,    16'd1, 16'd1};
        tv[4]  = '{1, 32'h3000, BEQ4,  0, 1,  1, 1, 32'h3014, 0, 32'h0,    16'd1, 16'd1};
        tv[5]  = '{1, 32'h3000, BEQ4,  0, 1,  1, 1, 32'h3014, 0, 32'h0,    16'd2, 16'd1};
        tv[6]  = '{1, 32'h3000, BEQ4,  0, 1,  1, 1, 32'h3014, 0, 32'h0,    16'd3, 16'd1};
        tv[7]  = '{1, 32'h3000, BEQ4,  0, 1,  1, 1, 32'h3014, 0, 32'h0,    16'd4, 16'd1};
        tv[8]  = '{1, 32'h3000, NOP,   0, 0,  1, 0, 32'h3004, 1, 32'h3004, 16'd5, 16'd1};
        tv[9]  = '{1, 32'h3000, BEQ4,  0, 0,  1, 1, 32'h3014, 0, 32'h0,    16'd6, 16'd2};
        tv[10] = '{1, 32'h3000, NOP,   1, 0,  1, 0, 32'h3004, 0, 32'h0,    16'd6, 16'd2};
        tv[11] = '{1, 32'h3000, NOP,   1, 1,  1, 0, 32'h3004, 0, 32'h0,    16'd6, 16'd2};
        tv[12] = '{1, 32'h3000, NOP,   1, 0,  1, 0, 32'h3004, 0, 32'h0,    16'd6, 16'd2};
        tv[13] = '{1, 32'h3000, NOP,   0, 1,  1, 0, 32'h3004, 0, 32'h0,    16'd6, 16'd2};
        tv[14] = '{1, 32'h3000, BEQ4,  0, 0,  1, 1, 32'h3014, 0, 32'h0,    16'd7, 16'd2};
        tv[15] = '{1, 32'h0,    BNEM1, 0, 0,  1, 1, 32'h0,    1, 32'h3004, 16'd7, 16'd2};
        tv[16] = '{1, 32'h3000, NOP,   0, 1,  1, 0, 32'h3004, 0, 32'h0,    16'd8, 16'd3};
        tv[17] = '{1, 32'h3000, BEQ4,  0, 0,  1, 1, 32'h3014, 0, 32'h0,    16'd8, 16'd3};
        tv[18] = '{0, 32'h3000, BEQ4,  0, 0,  0, 0, 32'h0,    0, 32'h0,    16'd0, 16'd0};
        tv[19] = '{1, 32'h0,    BNEM1, 0, 1,  1, 0, 32'h4,    0, 32'h0,    16'd0, 16'd0};

        for (int i = 0; i < 20; i++) begin
            drive_and_check(tv[i].rst, tv[i].pc, tv[i].instr, tv[i].st, tv[i].dt);
            if (tv[i].chk_en) begin
                chk($sformatf("vec%0d_pred_taken", i), 32'(F_pred_taken), 32'(tv[i].ept));
                chk($sformatf("vec%0d_pred_pc", i), F_pred_pc, tv[i].eppc);
                chk($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(tv[i].emis));
                if (tv[i].emis) chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, tv[i].erpc);
                chk($sformatf("vec%0d_br_cnt", i), 32'(br_cnt), 32'(tv[i].ebr));
                chk($sformatf("vec%0d_miss_cnt", i), 32'(miss_cnt), 32'(tv[i].emiss));
            end
            clock_edge();
        end

        // After the mid-stream reset every entry reads weak-not-taken.
        for (int k = 0; k < 64; k++) begin
            drive_and_check(1'b1, 32'(k * 4), BEQ4, 1'b1, 1'b0);
            chk($sformatf("post_reset_idx%0d", k), 32'(F_pred_taken), 32'd0);
            clock_edge();
        end

        // Randomized traffic with index aliasing and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom;
            if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
            else pc = 32'($urandom_range(0, 127)) << 2;
            case ($urandom_range(0, 3))
                0: op = 6'd4;
                1: op = 6'd5;
                2: op = 6'($urandom_range(0, 63));
                default: op = 6'd4;
            endcase
            instr = {op, r[25:0]};
            drive_and_check(($urandom_range(0, 299) != 0), pc, instr,
                            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            clock_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
